// File: rtl/bullet_hit_ctrl.sv
// rtl/bullet_hit_ctrl.sv - one shooter's bullet: launch, move, enemy hit detection, cooldown
// Optional HIT_SCORE_EN adds a saturating hit_count output.
module bullet_hit_ctrl #(
  parameter logic [31:0] MOVE_DIV = 32'd750000,
  parameter logic [31:0] COOLDOWN = 32'd37500000,
  parameter int          HIT_W    = 4,
  parameter int          HIT_H    = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fire,
  input  logic [7:0] shooter_x,
  input  logic [7:0] shooter_y,
  input  logic [2:0] shooter_dir,
  input  logic [7:0] target_x,
  input  logic [7:0] target_y,
  input  logic       target_burst,
  output logic       hit,
  output logic [7:0] bullet_x,
  output logic [7:0] bullet_y,
  output logic       bullet_active,
  output logic [1:0] state_o
`ifdef HIT_SCORE_EN
  ,
  output logic [7:0] hit_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FLY  = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  localparam logic [8:0] HW_M1 = 9'(HIT_W - 1);
  localparam logic [8:0] HH_M1 = 9'(HIT_H - 1);

  logic [1:0]  state;
  logic        fire_q;
  logic [2:0]  dir;
  logic [31:0] move_cnt;
  logic [31:0] cool_cnt;

  logic        fire_rise;
  logic [8:0]  bx9, by9, nx, ny;
  logic        collide;
  logic        step_due;
  logic        exit_edge;
  logic        cool_done;

  assign fire_rise = fire & ~fire_q;
  assign state_o   = state;

  // Hit box compares are done 9 bits wide so target+size cannot wrap.
  assign bx9     = {1'b0, bullet_x};
  assign by9     = {1'b0, bullet_y};
  assign collide = (bx9 >= {1'b0, target_x}) && (bx9 <= {1'b0, target_x} + HW_M1) &&
                   (by9 >= {1'b0, target_y}) && (by9 <= {1'b0, target_y} + HH_M1);

  assign step_due  = (MOVE_DIV <= 32'd1) || (move_cnt == MOVE_DIV - 32'd1);
  assign cool_done = (COOLDOWN == 32'd0) || (cool_cnt == COOLDOWN - 32'd1);

  always_comb begin
    nx = bx9;
    ny = by9;
    case (dir)
      3'b000:  ny = by9 - 9'd1;
      3'b010:  nx = bx9 + 9'd1;
      3'b100:  ny = by9 + 9'd1;
      3'b110:  nx = bx9 - 9'd1;
      default: ;
    endcase
  end

  // A step below 0 wraps to 0x1FF, so one "> 127" test covers both edges.
  assign exit_edge = dir[1] ? (nx > 9'd127) : (ny > 9'd127);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      fire_q        <= 1'b1;
      dir           <= 3'b000;
      move_cnt      <= 32'd0;
      cool_cnt      <= 32'd0;
      hit           <= 1'b0;
      bullet_x      <= 8'd0;
      bullet_y      <= 8'd0;
      bullet_active <= 1'b0;
`ifdef HIT_SCORE_EN
      hit_count     <= 8'd0;
`endif
    end else begin
      fire_q <= fire;
      hit    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fire_rise && !shooter_dir[0]) begin
            dir           <= shooter_dir;
            bullet_x      <= shooter_x + 8'd2;
            bullet_y      <= shooter_y + 8'd3;
            bullet_active <= 1'b1;
            move_cnt      <= 32'd0;
            state         <= S_FLY;
          end
        end
        S_FLY: begin
          if (collide && !target_burst) begin
            hit           <= 1'b1;
            bullet_active <= 1'b0;
            cool_cnt      <= 32'd0;
            state         <= S_COOL;
`ifdef HIT_SCORE_EN
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
`endif
          end else if (step_due) begin
            move_cnt <= 32'd0;
            if (exit_edge) begin
              bullet_active <= 1'b0;
              cool_cnt      <= 32'd0;
              state         <= S_COOL;
            end else begin
              bullet_x <= nx[7:0];
              bullet_y <= ny[7:0];
            end
          end else begin
            move_cnt <= move_cnt + 32'd1;
          end
        end
        S_COOL: begin
          bullet_active <= 1'b0;
          if (cool_done) begin
            cool_cnt <= 32'd0;
            state    <= S_IDLE;
          end else begin
            cool_cnt <= cool_cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_hit_ctrl.sv
// tb/tb_bullet_hit_ctrl.sv - directed checks of bullet_hit_ctrl with MOVE_DIV=4, COOLDOWN=8
module tb_bullet_hit_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       fire;
  logic [7:0] shooter_x, shooter_y, target_x, target_y;
  logic [2:0] shooter_dir;
  logic       target_burst;
  logic       hit;
  logic [7:0] bullet_x, bullet_y;
  logic       bullet_active;
  logic [1:0] state_o;
`ifdef HIT_SCORE_EN
  logic [7:0] hit_count;
`endif

  int checks = 0;
  int errors = 0;
  int hit_seen = 0;

  always #5 clock = ~clock;

  bullet_hit_ctrl #(.MOVE_DIV(32'd4), .COOLDOWN(32'd8), .HIT_W(4), .HIT_H(6)) dut (
    .clock(clock), .reset(reset), .fire(fire),
    .shooter_x(shooter_x), .shooter_y(shooter_y), .shooter_dir(shooter_dir),
    .target_x(target_x), .target_y(target_y), .target_burst(target_burst),
    .hit(hit), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .state_o(state_o)
`ifdef HIT_SCORE_EN
    , .hit_count(hit_count)
`endif
  );

  typedef struct {
    logic [7:0] sx;
    logic [7:0] sy;
    logic [2:0] dir;
    logic [1:0] exp_state;
    logic [7:0] exp_bx;
    logic [7:0] exp_by;
    logic       exp_active;
  } launch_vec_t;

  launch_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (hit) hit_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fire  = 1'b0;
    ticks(2);
    reset = 1'b0;
    tick();
    hit_seen = 0;
  endtask

  task automatic launch(input logic [7:0] sx, input logic [7:0] sy, input logic [2:0] d);
    shooter_x   = sx;
    shooter_y   = sy;
    shooter_dir = d;
    fire = 1'b1;
    tick();
    fire = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fire = 1'b0;
    shooter_x = 8'd0; shooter_y = 8'd0; shooter_dir = 3'b000;
    target_x = 8'd200; target_y = 8'd200; target_burst = 1'b0;

    vecs[0] = '{8'd10,  8'd20,  3'b010, 2'd1, 8'd12,  8'd23, 1'b1};
    vecs[1] = '{8'd0,   8'd0,   3'b000, 2'd1, 8'd2,   8'd3,  1'b1};
    vecs[2] = '{8'd254, 8'd253, 3'b100, 2'd1, 8'd0,   8'd0,  1'b1};
    vecs[3] = '{8'd100, 8'd5,   3'b110, 2'd1, 8'd102, 8'd8,  1'b1};
    vecs[4] = '{8'd5,   8'd5,   3'b001, 2'd0, 8'd0,   8'd0,  1'b0};
    vecs[5] = '{8'd5,   8'd5,   3'b011, 2'd0, 8'd0,   8'd0,  1'b0};
    vecs[6] = '{8'd5,   8'd5,   3'b111, 2'd0, 8'd0,   8'd0,  1'b0};

    ticks(2);
    check("reset_state", state_o, 0);
    check("reset_hit", hit, 0);
    check("reset_active", bullet_active, 0);
    check("reset_bx", bullet_x, 0);
    check("reset_by", bullet_y, 0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      launch(vecs[v].sx, vecs[v].sy, vecs[v].dir);
      check($sformatf("vec%0d_state", v), state_o, vecs[v].exp_state);
      check($sformatf("vec%0d_bx", v), bullet_x, vecs[v].exp_bx);
      check($sformatf("vec%0d_by", v), bullet_y, vecs[v].exp_by);
      check($sformatf("vec%0d_active", v), bullet_active, vecs[v].exp_active);
    end

    // East shot into the target
    do_reset();
    target_x = 8'd30; target_y = 8'd20; target_burst = 1'b0;
    launch(8'd10, 8'd20, 3'b010);
    check("east_launch_bx", bullet_x, 12);
    check("east_launch_by", bullet_y, 23);
    ticks(3);
    check("east_hold_bx", bullet_x, 12);
    tick();
    check("east_step_bx", bullet_x, 13);
    ticks(68);
    check("east_at_target_bx", bullet_x, 30);
    check("east_no_early_hit", hit_seen, 0);
    tick();
    check("east_hit", hit, 1);
    check("east_hit_state", state_o, 2);
    check("east_hit_active", bullet_active, 0);
    tick();
    check("east_hit_one_cycle", hit, 0);
    check("east_cool", state_o, 2);
    ticks(6);
    check("east_cool_end", state_o, 2);
    tick();
    check("east_idle", state_o, 0);
    check("east_hit_total", hit_seen, 1);

    // North edge exit
    do_reset();
    target_x = 8'd100; target_y = 8'd100;
    launch(8'd50, 8'd1, 3'b000);
    check("north_launch_by", bullet_y, 4);
    check("north_launch_bx", bullet_x, 52);
    ticks(16);
    check("north_at_edge_by", bullet_y, 0);
    check("north_still_fly", state_o, 1);
    ticks(3);
    check("north_fly_before_exit", state_o, 1);
    tick();
    check("north_exit_cool", state_o, 2);
    check("north_exit_active", bullet_active, 0);
    check("north_exit_by", bullet_y, 0);
    ticks(7);
    check("north_cool_end", state_o, 2);
    tick();
    check("north_idle", state_o, 0);
    check("north_no_hit", hit_seen, 0);

    // Burst invulnerability: passes through and leaves at x=127
    do_reset();
    target_x = 8'd30; target_y = 8'd20; target_burst = 1'b1;
    launch(8'd10, 8'd20, 3'b010);
    ticks(460);
    check("burst_bx_edge", bullet_x, 127);
    check("burst_still_fly", state_o, 1);
    check("burst_no_hit", hit_seen, 0);
    ticks(4);
    check("burst_exit_cool", state_o, 2);
    check("burst_exit_active", bullet_active, 0);
    check("burst_no_hit_end", hit_seen, 0);
    target_burst = 1'b0;

    // Fire held high across reset release
    reset = 1'b1; fire = 1'b1;
    shooter_x = 8'd10; shooter_y = 8'd20; shooter_dir = 3'b010;
    ticks(2);
    reset = 1'b0;
    ticks(3);
    check("held_fire_idle", state_o, 0);
    check("held_fire_active", bullet_active, 0);
    fire = 1'b0;

    // Second fire during flight is dropped
    do_reset();
    target_x = 8'd100; target_y = 8'd100;
    launch(8'd50, 8'd1, 3'b000);
    ticks(5);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
    check("refire_state", state_o, 1);
    check("refire_by", bullet_y, 3);
    ticks(21);
    check("refire_idle", state_o, 0);
    ticks(5);
    check("refire_no_relaunch", state_o, 0);
    check("refire_no_active", bullet_active, 0);

    // Reset mid-flight
    do_reset();
    target_x = 8'd30; target_y = 8'd20;
    launch(8'd10, 8'd20, 3'b010);
    ticks(32);
    check("midflight_bx", bullet_x, 20);
    reset = 1'b1;
    tick();
    check("abort_state", state_o, 0);
    check("abort_active", bullet_active, 0);
    check("abort_bx", bullet_x, 0);
    check("abort_by", bullet_y, 0);
    check("abort_hit", hit, 0);
    reset = 1'b0;

`ifdef HIT_SCORE_EN
    do_reset();
    check("score_reset", hit_count, 0);
    target_x = 8'd30; target_y = 8'd20;
    for (int s = 0; s < 3; s++) begin
      launch(8'd28, 8'd17, 3'b010);
      ticks(10);
    end
    check("score_three", hit_count, 3);
    for (int s = 0; s < 255; s++) begin
      launch(8'd28, 8'd17, 3'b010);
      ticks(10);
    end
    check("score_saturate", hit_count, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_hit_ctrl.md
Name: bullet_hit_ctrl

Overview:
- Upstream stage of the tank icon renderer: owns one shooter's bullet, moves it across the 128x128 Rojobot map and detects collision with the enemy tank.
- Drives the enemy icon stage's hit input with a one-cycle pulse.
- Exports the bullet map location for the bullet sprite stage.
- One instance per shooter, e.g. blue tank firing at red.

Parameters:
- MOVE_DIV, 32'd750000: clock cycles between single-unit bullet moves; 100 moves/s at 75 MHz.
- COOLDOWN, 32'd37500000: cycles in COOL before another shot is accepted; 0.5 s.
- HIT_W, 4: target hit-box width in map units; a 32-px icon at 8 px/unit.
- HIT_H, 6: target hit-box height in map units; a 32-px icon at 6 px/unit, rounded up.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- fire  in  1  debounced fire button, level.
- shooter_x  in  8  shooter LocX, map units.
- shooter_y  in  8  shooter LocY, map units.
- shooter_dir  in  3  shooter BotInfo[2:0]: 000 N, 010 E, 100 S, 110 W.
- target_x  in  8  enemy LocX.
- target_y  in  8  enemy LocY.
- target_burst  in  1  enemy icon stage is showing burst; enemy is invulnerable while high.
- hit  out  1  one-cycle pulse on collision.
- bullet_x  out  8  bullet map X.
- bullet_y  out  8  bullet map Y.
- bullet_active  out  1  bullet in flight; gates the sprite.
- state_o  out  2  current state: 0 IDLE, 1 FLY, 2 COOL.

Behaviour:
Reset:
- State IDLE.
- hit=0, bullet_active=0, bullet_x=0, bullet_y=0.
- Move and cooldown counters = 0.
- fire_q=1, so a fire level held across reset does not launch.
- Reset asserted mid-flight or mid-cooldown aborts immediately to this state; no hit is emitted.

Fire detection:
- fire_rise = fire & ~fire_q. fire_q is registered every cycle.

IDLE:
- On fire_rise with shooter_dir in {000,010,100,110}:
  - latch dir;
  - bullet_x = shooter_x+2, bullet_y = shooter_y+3, 8-bit wrap;
  - bullet_active=1, move counter = 0, go to FLY next cycle.
- fire_rise with any other shooter_dir is ignored and the state stays IDLE.

FLY:
- Collision is evaluated every cycle on the registered bullet position. Compares use 9-bit zero-extended values:
  - target_x <= bullet_x <= target_x+HIT_W-1
  - target_y <= bullet_y <= target_y+HIT_H-1
- On collision with target_burst=0:
  - hit=1 for exactly that cycle's registered output;
  - bullet_active=0, go to COOL.
- Collision takes priority over a move in the same cycle.
- Collision while target_burst=1: no hit; the bullet keeps flying.
- Moves:
  - The move counter increments each cycle.
  - At MOVE_DIV-1 it resets and the bullet steps one unit: N y-1, S y+1, E x+1, W x-1.
- Edge exit: if the step would take x or y below 0 or above 127, do not step; set bullet_active=0 and go to COOL with no hit.
- Direction is latched at launch; shooter_dir changes during flight are ignored.

COOL:
- bullet_active=0.
- The counter counts to COOLDOWN-1, then the state goes to IDLE.
- COOLDOWN=0 returns to IDLE the next cycle.

Fire handling outside IDLE:
- fire_rise in FLY or COOL is dropped, not queued.

hit register:
- Registered output; defaults to 0 every cycle unless set as above.
- Never high for two consecutive cycles.

Optional Feature:
- Macro: HIT_SCORE_EN.
- Defined:
  - adds output hit_count [7:0], reset 0;
  - increments on each hit pulse and saturates at 255;
  - used by the scoreboard.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- All tests use MOVE_DIV=4, COOLDOWN=8.
- East shot hits: reset; shooter (10,20) dir 010; target (30,20); pulse fire.
  - Expected: FLY with bullet (12,23); x increments every 4 cycles.
  - hit is exactly one cycle when bullet_x=30; state then COOL, bullet_active=0.
- North edge exit: shooter (50,1) dir 000; target far away; fire.
  - Expected: bullet starts at y=4 and steps to y=0.
  - The next move goes to COOL with no hit, then IDLE 8 cycles later.
- Burst invulnerability: same as the east-shot case but target_burst=1 throughout.
  - Expected: no hit; the bullet passes through the target and exits at x=127.
- Ignored inputs:
  - fire held high through reset release: no launch.
  - fire_rise with dir 001: stays IDLE.
  - second fire_rise during FLY: no effect, and no relaunch after COOL.
- Reset mid-flight: assert reset while bullet_x=20.
  - Expected: next cycle state IDLE, bullet_active=0, bullet (0,0), hit=0.
- HIT_SCORE_EN: three consecutive hitting shots.
  - Expected: hit_count = 3.
  - Forcing 256 hits leaves hit_count at 255.
